// File: rtl/viterbi_frame_ctrl_if.sv
// Viterbi frame controller bus.
// Groups the symbol handshake, ACS controls, survivor-memory addressing,
// traceback controls and the decoded-bit output handshake.
//   master : the frame controller (drives SYM_READY, ACS_*, SM_*, TB_START,
//            TB_EN, OUT_BIT, OUT_VALID, BUSY, FRAME_DONE)
//   slave  : the surrounding datapath / upstream / downstream (drives
//            SYM_VALID, TB_BIT, OUT_READY)
interface viterbi_frame_ctrl_if #(
    parameter int AW = 5
);
    logic          SYM_VALID;
    logic          SYM_READY;
    logic          ACS_EN;
    logic          ACS_CLR;
    logic          SM_WE;
    logic [AW-1:0] SM_WADDR;
    logic [AW-1:0] SM_RADDR;
    logic          TB_START;
    logic          TB_EN;
    logic          TB_BIT;
    logic          OUT_BIT;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic          BUSY;
    logic          FRAME_DONE;

    modport master (
        input  SYM_VALID, TB_BIT, OUT_READY,
        output SYM_READY, ACS_EN, ACS_CLR, SM_WE, SM_WADDR, SM_RADDR,
               TB_START, TB_EN, OUT_BIT, OUT_VALID, BUSY, FRAME_DONE
    );

    modport slave (
        output SYM_VALID, TB_BIT, OUT_READY,
        input  SYM_READY, ACS_EN, ACS_CLR, SM_WE, SM_WADDR, SM_RADDR,
               TB_START, TB_EN, OUT_BIT, OUT_VALID, BUSY, FRAME_DONE
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Viterbi decoder frame sequencer.
// Accepts FRAME_LEN symbol pairs (driving ACS enable/clear and survivor
// writes), runs traceback over the whole frame from the last stage down to
// stage 0, buffers the reverse-order decoded bits and then emits them in
// forward order, dropping the TAIL termination bits.
// Ports:
//   CLOCK : rising-edge clock
//   RESET : asynchronous active-low reset (aborts any frame in flight)
//   bus   : viterbi_frame_ctrl_if.master, all handshake / control signals
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 32,
    parameter int AW        = 5,
    parameter int TAIL      = 2
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    viterbi_frame_ctrl_if.master    bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACS  = 2'd1;
    localparam logic [1:0] S_TB   = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] LAST_OUT  = AW'(FRAME_LEN - TAIL - 1);

    logic [1:0]           state_q;
    logic [AW-1:0]        wcnt_q;
    logic [AW-1:0]        rcnt_q;
    logic [AW-1:0]        ocnt_q;
    logic                 tb_last_q;   // final TB cycle: no step, only capture
    logic                 cap_vld_q;   // TB_EN of the previous cycle
    logic [AW-1:0]        cap_addr_q;  // stage address of the previous TB_EN
    logic [FRAME_LEN-1:0] bit_buf_q;

    logic sym_hs;
    logic sym_acc;
    logic out_hs;
    logic tb_en;

    assign bus.SYM_READY = (state_q == S_IDLE) || (state_q == S_ACS);
    assign sym_hs        = bus.SYM_VALID & bus.SYM_READY;
    // RESET gates the datapath strobes so nothing fires while reset is held,
    // even with a symbol waiting upstream.
    assign sym_acc       = sym_hs & RESET;

    assign bus.ACS_EN    = sym_acc;
    assign bus.SM_WE     = sym_acc;
    assign bus.ACS_CLR   = sym_acc & (state_q == S_IDLE);
    assign bus.SM_WADDR  = (state_q == S_ACS) ? wcnt_q : '0;

    assign tb_en         = (state_q == S_TB) & ~tb_last_q;
    assign bus.TB_EN     = tb_en;
    // rcnt only equals the last stage on entry to traceback
    assign bus.TB_START  = tb_en & (rcnt_q == LAST_ADDR);
    assign bus.SM_RADDR  = tb_en ? rcnt_q : '0;

    assign bus.OUT_VALID  = (state_q == S_OUT);
    assign bus.OUT_BIT    = bus.OUT_VALID & bit_buf_q[ocnt_q];
    assign out_hs         = bus.OUT_VALID & bus.OUT_READY;
    assign bus.FRAME_DONE = out_hs & (ocnt_q == LAST_OUT);
    assign bus.BUSY       = (state_q != S_IDLE);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            ocnt_q     <= '0;
            tb_last_q  <= 1'b0;
            cap_vld_q  <= 1'b0;
            cap_addr_q <= '0;
            bit_buf_q  <= '0;
        end else begin
            // TB_BIT answers the TB_EN of the previous cycle
            cap_vld_q  <= tb_en;
            cap_addr_q <= rcnt_q;
            if (cap_vld_q) begin
                bit_buf_q[cap_addr_q] <= bus.TB_BIT;
            end

            case (state_q)
                S_IDLE: begin
                    if (sym_hs) begin
                        state_q <= S_ACS;
                        wcnt_q  <= AW'(1);
                    end
                end
                S_ACS: begin
                    if (sym_hs) begin
                        if (wcnt_q == LAST_ADDR) begin
                            state_q   <= S_TB;
                            wcnt_q    <= '0;
                            rcnt_q    <= LAST_ADDR;
                            tb_last_q <= 1'b0;
                        end else begin
                            wcnt_q <= wcnt_q + AW'(1);
                        end
                    end
                end
                S_TB: begin
                    if (tb_last_q) begin
                        state_q   <= S_OUT;
                        tb_last_q <= 1'b0;
                        ocnt_q    <= '0;
                    end else if (rcnt_q == '0) begin
                        tb_last_q <= 1'b1;
                    end else begin
                        rcnt_q <= rcnt_q - AW'(1);
                    end
                end
                default: begin  // S_OUT
                    if (out_hs) begin
                        if (ocnt_q == LAST_OUT) begin
                            state_q <= S_IDLE;
                            ocnt_q  <= '0;
                        end else begin
                            ocnt_q <= ocnt_q + AW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
- Frame sequencer for the Viterbi decoder.
- Accepts received symbol pairs by handshake and drives the ACS (add-compare-select) stage enable and path-metric clear.
- Generates survivor-memory write and read addresses, then runs traceback over the whole frame.
- Buffers the decoded bits, which arrive in reverse order, and emits them in forward order without the tail bits.

Parameters:
FRAME_LEN, 32, trellis stages per frame including tail; must be at least TAIL+1 and at least 2
AW, 5, address width, ceil(log2(FRAME_LEN))
TAIL, 2, termination tail bits (K-1), dropped from the output

Ports:
CLOCK  in  1  single clock, rising edge
RESET  in  1  asynchronous, active-low reset
SYM_VALID  in  1  symbol pair available from upstream
SYM_READY  out  1  controller accepts a symbol
ACS_EN  out  1  ACS datapath updates metrics/survivors this cycle
ACS_CLR  out  1  load initial metrics (state 0 = 0, others = max) this cycle
SM_WE  out  1  survivor memory write enable
SM_WADDR  out  AW  survivor memory write address
SM_RADDR  out  AW  survivor memory read address
TB_START  out  1  traceback unit starts from state 0
TB_EN  out  1  traceback unit steps one stage
TB_BIT  in  1  decoded bit, valid exactly 1 cycle after each TB_EN
OUT_BIT  out  1  decoded bit, forward order
OUT_VALID  out  1  OUT_BIT valid
OUT_READY  in  1  downstream accepts OUT_BIT
BUSY  out  1  high in every state except IDLE
FRAME_DONE  out  1  high during the cycle of the last output handshake

Behaviour:
- Clocking and reset: one clock. RESET is asynchronous and active-low.
- RESET low state: state=IDLE, counters=0, bit buffer=0, TB_BIT capture pipe cleared. All outputs are 0 except SYM_READY=1.
- Reset mid-frame aborts the frame. No FRAME_DONE is issued and no partial output appears afterwards.
- Handshakes: SYM_VALID&SYM_READY on a rising edge, and OUT_VALID&OUT_READY on a rising edge.
- Control outputs are combinational from the registered state/counters and the input handshake. There is no extra latency.
- IDLE: SYM_READY=1.
  - On handshake: ACS_CLR=1, ACS_EN=1, SM_WE=1, SM_WADDR=0.
  - Next state ACS with wcnt=1.
- ACS: SYM_READY=1.
  - Per handshake: ACS_EN=SM_WE=1, SM_WADDR=wcnt, wcnt increments.
  - No handshake: ACS_EN=SM_WE=0, wcnt holds.
  - Handshake with wcnt==FRAME_LEN-1: next state TB, rcnt=FRAME_LEN-1.
- TB: SYM_READY=0.
  - For FRAME_LEN cycles: TB_EN=1, SM_RADDR=rcnt, rcnt decrements each cycle.
  - TB_START=1 only in the first TB cycle.
  - TB_EN at address a is registered; in the following cycle TB_BIT is written to buf[a].
  - The cycle after rcnt==0 (TB_EN=0) captures the last bit; next state OUT with ocnt=0.
  - TB occupies FRAME_LEN+1 cycles.
- OUT: SYM_READY=0, OUT_VALID=1, OUT_BIT=buf[ocnt].
  - ocnt increments only on handshake. OUT_BIT stays stable while OUT_READY=0.
  - Handshake with ocnt==FRAME_LEN-TAIL-1: FRAME_DONE=1 that cycle, next state IDLE.
  - buf[FRAME_LEN-TAIL .. FRAME_LEN-1] are never output.
- SYM_VALID during TB/OUT is ignored: no ACS_EN, no SM_WE. A held symbol is accepted in the first IDLE cycle, with ACS_CLR.
- Minimum frame period with no stalls is FRAME_LEN + (FRAME_LEN+1) + (FRAME_LEN-TAIL) cycles.
- Counters never wrap past FRAME_LEN-1. Addresses are always below FRAME_LEN.

Test Plan:
1. Reset, then SYM_VALID=1 continuously, FRAME_LEN=8, TAIL=2, OUT_READY=1 -> ACS_CLR only on the first symbol; SM_WADDR 0..7 on 8 consecutive cycles. Then SYM_READY=0, TB_START one cycle, SM_RADDR 7,6,...,0 with TB_EN; 9 TB cycles; 6 OUT cycles; FRAME_DONE on the 6th; back to IDLE.
2. TB_BIT responses for RADDR 7..0 = 0,0,1,0,1,1,0,1 -> OUT_BIT sequence 1,0,1,1,0,1. Tail bits 0,0 at buf[6], buf[7] are not emitted.
3. SYM_VALID pattern 1,0,0,1,1,0,1... across a frame -> ACS_EN/SM_WE only on handshake cycles; SM_WADDR contiguous 0..7 with no gaps or repeats.
4. OUT_READY low for 3 cycles at ocnt=2 -> OUT_VALID=1, OUT_BIT=buf[2] held, ocnt=2 throughout; resumes at buf[3] after OUT_READY=1.
5. SYM_VALID held high through TB and OUT -> no ACS_EN or SM_WE until IDLE. First IDLE cycle: ACS_CLR=1, SM_WADDR=0.
6. RESET pulsed low mid-TB (rcnt=4) -> all outputs 0 except SYM_READY=1 immediately (asynchronous), no FRAME_DONE. The next frame completes as in test 1.
